dvp_pattern_tx: RTL and testbench

- Single-clock DVP camera-side source: emulates the OV5640 8-bit RGB565 output stream (cam_pclk, cam_vsync, cam_href, cam_data) with synthetic test patterns.
- Drives the capture path in bench and board loopback without a sensor. It is the transmitter for the existing cmos capture receiver.
- Frame geometry uses the same 13-bit h/v pixel and total-size inputs already used to configure the camera.

---
 rtl/dvp_pkg.sv | 43 ++++
 rtl/dvp_pattern_gen.sv | 66 ++++++
 rtl/dvp_pattern_tx.sv | 235 +++++++++++++++++++++++
 tb/tb_dvp_pattern_tx.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dvp_pkg.sv
// Shared definitions for the DVP pattern transmitter: FSM state codes,
// pattern_sel encodings and the RGB565 colour-bar palette.
package dvp_pkg;

    // FSM state codes
    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StVsync  = 3'd1;
    localparam logic [2:0] StVbp    = 3'd2;
    localparam logic [2:0] StActive = 3'd3;
    localparam logic [2:0] StVfp    = 3'd4;

    // pattern_sel encodings
    localparam logic [1:0] PatBars  = 2'd0;
    localparam logic [1:0] PatGrad  = 2'd1;
    localparam logic [1:0] PatSolid = 2'd2;
    localparam logic [1:0] PatCheck = 2'd3;

    // Colour-bar palette, left to right
    localparam logic [15:0] ColWhite   = 16'hFFFF;
    localparam logic [15:0] ColYellow  = 16'hFFE0;
    localparam logic [15:0] ColCyan    = 16'h07FF;
    localparam logic [15:0] ColGreen   = 16'h07E0;
    localparam logic [15:0] ColMagenta = 16'hF81F;
    localparam logic [15:0] ColRed     = 16'hF800;
    localparam logic [15:0] ColBlue    = 16'h001F;
    localparam logic [15:0] ColBlack   = 16'h0000;

    function automatic logic [15:0] bar_colour(input logic [2:0] idx);
        logic [15:0] col;
        unique case (idx)
            3'd0:    col = ColWhite;
            3'd1:    col = ColYellow;
            3'd2:    col = ColCyan;
            3'd3:    col = ColGreen;
            3'd4:    col = ColMagenta;
            3'd5:    col = ColRed;
            3'd6:    col = ColBlue;
            default: col = ColBlack;
        endcase
        return col;
    endfunction

endpackage

// File: rtl/dvp_pattern_gen.sv
// Pixel generator: returns the RGB565 value of pixel (x, y) for the selected
// pattern. x/y and the advance strobes describe the pixel about to be shown,
// so the bar lookup uses the next-state bar index.
module dvp_pattern_gen
    import dvp_pkg::*;
#(
    parameter logic [12:0] BAR_W  = 13'd80,
    parameter int unsigned CHK_SH = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [12:0] x,
    input  logic [12:0] y,
    input  logic [1:0]  mode,
    input  logic [15:0] solid,
    input  logic        x_adv,
    input  logic        line_start,
    output logic [15:0] rgb
);

    logic [12:0] bar_cnt_q, bar_cnt_d;
    logic [2:0]  bar_idx_q, bar_idx_d;

    // Running sub-counter replaces x / BAR_W; bar index wraps mod 8 naturally
    always_comb begin
        bar_cnt_d = bar_cnt_q;
        bar_idx_d = bar_idx_q;
        if (line_start) begin
            bar_cnt_d = '0;
            bar_idx_d = '0;
        end else if (x_adv) begin
            if (bar_cnt_q >= BAR_W - 13'd1) begin
                bar_cnt_d = '0;
                bar_idx_d = bar_idx_q + 3'd1;
            end else begin
                bar_cnt_d = bar_cnt_q + 13'd1;
            end
        end
    end

    // Bar position state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bar_cnt_q <= '0;
            bar_idx_q <= '0;
        end else begin
            bar_cnt_q <= bar_cnt_d;
            bar_idx_q <= bar_idx_d;
        end
    end

    // Pattern select
    always_comb begin
        rgb = '0;
        unique case (mode)
            PatBars:  rgb = bar_colour(bar_idx_d);
            PatGrad:  rgb = {x[4:0], x[5:0], x[4:0]};
            PatSolid: rgb = solid;
            default:  rgb = (x[CHK_SH] ^ y[CHK_SH]) ? 16'hFFFF : 16'h0000;
        endcase
    end

    logic unused_bits;
    assign unused_bits = ^{x, y};

endmodule

// File: rtl/dvp_pattern_tx.sv
// DVP (OV5640-style RGB565, 8-bit) test-pattern source. cam_pclk = clk/2;
// stream outputs change only on the clk edge where cam_pclk falls ("tick").
// Optional: define DVP_TX_FRAME_ID_EN to put a 16-bit frame counter in
// pixel 0 of active line 0.
module dvp_pattern_tx
    import dvp_pkg::*;
#(
    parameter int unsigned VS_LINES  = 2,
    parameter int unsigned VBP_LINES = 4,
    parameter logic [12:0] BAR_W     = 13'd80,
    parameter int unsigned CHK_SH    = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tx_en,
    input  logic [1:0]  pattern_sel,
    input  logic [15:0] solid_rgb,
    input  logic [12:0] cmos_h_pixel,
    input  logic [12:0] cmos_v_pixel,
    input  logic [12:0] total_h_pixel,
    input  logic [12:0] total_v_pixel,
    output logic        cam_pclk,
    output logic        cam_vsync,
    output logic        cam_href,
    output logic [7:0]  cam_data,
    output logic        frame_done,
    output logic        busy
);

    logic [2:0]  state_q, state_d;
    logic [12:0] x_q, x_d, y_q, y_d;
    logic        ph_q, ph_d;
    logic        pclk_q, pclk_d;
    logic        upd, load, x_adv, line_start, frame_end;
    logic [12:0] last_line;

    // Per-frame latched configuration
    logic [12:0] hl_q, vl_q, th_m1_q, vfp_q;
    logic [1:0]  mode_q;
    logic [15:0] solid_q;

    logic [12:0] hl_in, vl_in, th_m1_in, vfp_in;
    logic [14:0] vfp_sum, vfp_diff;

    logic        vsync_q, href_q, frame_done_q, busy_q;
    logic [7:0]  data_q;
    logic        href_d;
    logic [7:0]  data_d;
    logic [15:0] rgb, pix;

    // Clamp geometry at latch time: th-1 = max(total_h-1, hl), VFP floored at 0
    always_comb begin
        hl_in    = (cmos_h_pixel == '0) ? 13'd1 : cmos_h_pixel;
        vl_in    = (cmos_v_pixel == '0) ? 13'd1 : cmos_v_pixel;
        th_m1_in = (total_h_pixel > hl_in) ? total_h_pixel - 13'd1 : hl_in;
        vfp_sum  = 15'(VS_LINES + VBP_LINES) + {2'b00, vl_in};
        vfp_diff = {2'b00, total_v_pixel} - vfp_sum;
        vfp_in   = ({2'b00, total_v_pixel} > vfp_sum) ? vfp_diff[12:0] : 13'd0;
    end

    // Index of the last line of the current state
    always_comb begin
        last_line = '0;
        unique case (state_q)
            StVsync:  last_line = 13'(VS_LINES - 1);
            StVbp:    last_line = 13'(VBP_LINES - 1);
            StActive: last_line = vl_q - 13'd1;
            default:  last_line = vfp_q - 13'd1;
        endcase
    end

    // Timing FSM: byte phase, pixel and line counters advance once per tick
    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        ph_d       = ph_q;
        pclk_d     = 1'b0;
        upd        = 1'b0;
        load       = 1'b0;
        x_adv      = 1'b0;
        line_start = 1'b0;
        frame_end  = 1'b0;
        if (state_q == StIdle) begin
            if (tx_en) begin
                state_d    = StVsync;
                x_d        = '0;
                y_d        = '0;
                ph_d       = 1'b0;
                upd        = 1'b1;
                load       = 1'b1;
                line_start = 1'b1;
            end
        end else begin
            pclk_d = ~pclk_q;
            if (pclk_q) begin
                upd = 1'b1;
                if (!ph_q) begin
                    ph_d = 1'b1;
                end else begin
                    ph_d = 1'b0;
                    if (x_q == th_m1_q) begin
                        x_d        = '0;
                        line_start = 1'b1;
                        if (y_q == last_line) begin
                            y_d = '0;
                            unique case (state_q)
                                StVsync:  state_d = StVbp;
                                StVbp:    state_d = StActive;
                                StActive: begin
                                    if (vfp_q == '0) frame_end = 1'b1;
                                    else state_d = StVfp;
                                end
                                default:  frame_end = 1'b1;
                            endcase
                            // Back-to-back frames relatch config on this edge
                            if (frame_end) begin
                                if (tx_en) begin
                                    state_d = StVsync;
                                    load    = 1'b1;
                                end else begin
                                    state_d = StIdle;
                                end
                            end
                        end else begin
                            y_d = y_q + 13'd1;
                        end
                    end else begin
                        x_d   = x_q + 13'd1;
                        x_adv = 1'b1;
                    end
                end
            end
        end
    end

    // Timing state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            x_q     <= '0;
            y_q     <= '0;
            ph_q    <= 1'b0;
            pclk_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            ph_q    <= ph_d;
            pclk_q  <= pclk_d;
        end
    end

    // Frame configuration latch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hl_q    <= 13'd1;
            vl_q    <= 13'd1;
            th_m1_q <= 13'd1;
            vfp_q   <= '0;
            mode_q  <= PatBars;
            solid_q <= '0;
        end else if (load) begin
            hl_q    <= hl_in;
            vl_q    <= vl_in;
            th_m1_q <= th_m1_in;
            vfp_q   <= vfp_in;
            mode_q  <= pattern_sel;
            solid_q <= solid_rgb;
        end
    end

    dvp_pattern_gen #(
        .BAR_W  (BAR_W),
        .CHK_SH (CHK_SH)
    ) u_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .x          (x_d),
        .y          (y_d),
        .mode       (mode_q),
        .solid      (solid_q),
        .x_adv      (x_adv),
        .line_start (line_start),
        .rgb        (rgb)
    );

`ifdef DVP_TX_FRAME_ID_EN
    logic [15:0] frame_id_q;

    // Frame counter, advanced once per completed frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         frame_id_q <= '0;
        else if (frame_end) frame_id_q <= frame_id_q + 16'd1;
    end

    assign pix = (state_d == StActive && x_d == '0 && y_d == '0) ? frame_id_q : rgb;
`else
    assign pix = rgb;
`endif

    // Byte mux: high byte on phase 0, low byte on phase 1, zero outside href
    always_comb begin
        href_d = (state_d == StActive) && (x_d < hl_q);
        data_d = '0;
        if (href_d) data_d = ph_d ? pix[7:0] : pix[15:8];
    end

    // Registered stream outputs, loaded only on ticks
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q      <= 1'b0;
            href_q       <= 1'b0;
            data_q       <= '0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            frame_done_q <= frame_end;
            busy_q       <= (state_d != StIdle);
            if (upd) begin
                vsync_q <= (state_d == StVsync);
                href_q  <= href_d;
                data_q  <= data_d;
            end
        end
    end

    assign cam_pclk   = pclk_q;
    assign cam_vsync  = vsync_q;
    assign cam_href   = href_q;
    assign cam_data   = data_q;
    assign frame_done = frame_done_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_dvp_pattern_tx.sv
// Scoreboard bench for dvp_pattern_tx: frame configurations are queued as
// expected frame shapes and pixel bytes; a receiver-style monitor samples on
// cam_pclk rising edges and checks against the queues.
module tb_dvp_pattern_tx;

    localparam int VS  = 2;
    localparam int VBP = 4;
    localparam int BW  = 2;
    localparam int NF  = 10;

    typedef struct {
        int h; int v; int th; int tv; int pat; int solid;
    } cfg_t;

    typedef struct {
        int vs; int ticks; int hlen; int gap; int lines;
    } frame_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        tx_en = 1'b0;
    logic [1:0]  pattern_sel = '0;
    logic [15:0] solid_rgb = '0;
    logic [12:0] cmos_h_pixel = '0, cmos_v_pixel = '0;
    logic [12:0] total_h_pixel = '0, total_v_pixel = '0;
    logic        cam_pclk, cam_vsync, cam_href, frame_done, busy;
    logic [7:0]  cam_data;

    int checks = 0;
    int errors = 0;
    int frames_done = 0;
    bit mon_en = 1'b0;

    frame_t     exp_q[$];
    logic [7:0] byte_q[$];
    cfg_t       cfgs[NF];
    int         th_eff[NF];

    always #5 clk = ~clk;

    dvp_pattern_tx #(
        .VS_LINES  (VS),
        .VBP_LINES (VBP),
        .BAR_W     (13'(BW)),
        .CHK_SH    (3)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .tx_en         (tx_en),
        .pattern_sel   (pattern_sel),
        .solid_rgb     (solid_rgb),
        .cmos_h_pixel  (cmos_h_pixel),
        .cmos_v_pixel  (cmos_v_pixel),
        .total_h_pixel (total_h_pixel),
        .total_v_pixel (total_v_pixel),
        .cam_pclk      (cam_pclk),
        .cam_vsync     (cam_vsync),
        .cam_href      (cam_href),
        .cam_data      (cam_data),
        .frame_done    (frame_done),
        .busy          (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref_pixel(input cfg_t c, input int x, input int y);
        logic [15:0] bars[8];
        logic [12:0] xb;
        bars = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800, 16'h001F,
                 16'h0000};
        xb = 13'(x);
        case (c.pat)
            0:       return bars[(x / BW) % 8];
            1:       return {xb[4:0], xb[5:0], xb[4:0]};
            2:       return 16'(c.solid);
            default: return (((x >> 3) ^ (y >> 3)) & 1) != 0 ? 16'hFFFF : 16'h0000;
        endcase
    endfunction

    // Drive the config inputs and queue the frame they describe
    task automatic program_frame(input cfg_t c, input int idx, output int th);
        int hl, vl, vfp;
        frame_t f;
        logic [15:0] p;
        cmos_h_pixel  = 13'(c.h);
        cmos_v_pixel  = 13'(c.v);
        total_h_pixel = 13'(c.th);
        total_v_pixel = 13'(c.tv);
        pattern_sel   = 2'(c.pat);
        solid_rgb     = 16'(c.solid);
        hl  = (c.h == 0) ? 1 : c.h;
        vl  = (c.v == 0) ? 1 : c.v;
        th  = (c.th > hl) ? c.th : hl + 1;
        vfp = c.tv - (VS + VBP + vl);
        if (vfp < 0) vfp = 0;
        f.vs    = VS * 2 * th;
        f.ticks = (VS + VBP + vl + vfp) * 2 * th;
        f.hlen  = 2 * hl;
        f.gap   = 2 * (th - hl);
        f.lines = vl;
        exp_q.push_back(f);
        for (int y = 0; y < vl; y++) begin
            for (int x = 0; x < hl; x++) begin
                p = ref_pixel(c, x, y);
`ifdef DVP_TX_FRAME_ID_EN
                if (x == 0 && y == 0) p = 16'(idx);
`endif
                byte_q.push_back(p[15:8]);
                byte_q.push_back(p[7:0]);
            end
        end
    endtask

    task automatic wait_vsync_rise(input string name);
        int  n = 0;
        bit  prev = cam_vsync;
        bit  seen = 1'b0;
        while (n < 20000 && !seen) begin
            @(negedge clk);
            seen = cam_vsync && !prev;
            prev = cam_vsync;
            n++;
        end
        chk(name, 32'(seen), 32'd1);
    endtask

    // Receiver-side monitor
    bit     in_frame, pclk_prev, in_href, vs_done;
    int     tick_cnt, vs_cnt, line_cnt, run, low;
    frame_t cur;

    always @(negedge clk) begin
        if (!rst_n || !mon_en) begin
            in_frame  = 1'b0;
            pclk_prev = 1'b0;
            in_href   = 1'b0;
        end else begin
            if (frame_done) begin
                chk("frame_done_in_frame", 32'(in_frame), 32'd1);
                chk("frame_ticks", 32'(tick_cnt), 32'(cur.ticks));
                chk("vsync_ticks", 32'(vs_cnt), 32'(cur.vs));
                chk("href_lines", 32'(line_cnt), 32'(cur.lines));
                chk("href_low_at_end", 32'(in_href), 32'd0);
                in_frame = 1'b0;
                frames_done++;
            end
            if (cam_pclk && !pclk_prev) begin
                if (!in_frame) begin
                    chk("frame_starts_with_vsync", 32'(cam_vsync), 32'd1);
                    chk("frame_expected", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) cur = exp_q.pop_front();
                    in_frame = 1'b1;
                    tick_cnt = 0; vs_cnt = 0; line_cnt = 0; run = 0; low = 0;
                    in_href  = 1'b0; vs_done = 1'b0;
                end
                tick_cnt++;
                if (cam_vsync) begin
                    chk("vsync_contiguous", 32'(vs_done), 32'd0);
                    vs_cnt++;
                end else begin
                    vs_done = 1'b1;
                end
                if (cam_href) begin
                    if (!in_href && line_cnt > 0) chk("href_gap", 32'(low), 32'(cur.gap));
                    in_href = 1'b1;
                    run++;
                    chk("byte_available", 32'(byte_q.size() != 0), 32'd1);
                    if (byte_q.size() != 0) chk("pixel_byte", 32'(cam_data), 32'(byte_q.pop_front()));
                end else begin
                    if (in_href) begin
                        chk("href_len", 32'(run), 32'(cur.hlen));
                        line_cnt++;
                        run = 0;
                        low = 0;
                    end
                    in_href = 1'b0;
                    low++;
                    chk("data_zero_outside_href", 32'(cam_data), 32'd0);
                end
            end
            pclk_prev = cam_pclk;
        end
    end

    initial begin
        int th, n, ignore;
        cfg_t rc;

        // Directed frames then random ones
        cfgs[0] = '{h: 4,  v: 2, th: 6,  tv: 8,  pat: 2, solid: 'hA55A};
        cfgs[1] = '{h: 16, v: 2, th: 20, tv: 10, pat: 0, solid: 0};
        cfgs[2] = '{h: 4,  v: 1, th: 2,  tv: 3,  pat: 3, solid: 0};
        cfgs[3] = '{h: 64, v: 2, th: 70, tv: 9,  pat: 1, solid: 0};
        cfgs[4] = '{h: 20, v: 9, th: 24, tv: 16, pat: 3, solid: 0};
        for (int i = 5; i < NF; i++) begin
            rc.h = int'($urandom_range(0, 20));
            rc.v = int'($urandom_range(0, 4));
            rc.th = int'($urandom_range(0, 30));
            rc.tv = int'($urandom_range(0, 14));
            rc.pat = int'($urandom_range(0, 3));
            rc.solid = int'($urandom_range(0, 65535));
            cfgs[i] = rc;
        end

        // Reset state
        #1 rst_n = 1'b0;
        #1;
        chk("reset_outputs", 32'({cam_pclk, cam_vsync, cam_href, cam_data, frame_done, busy}), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_outputs", 32'({cam_pclk, cam_vsync, cam_href, cam_data, frame_done, busy}), 32'd0);

        // Async reset during ACTIVE (monitor disabled for the aborted frame)
        cmos_h_pixel = 13'd8; cmos_v_pixel = 13'd2;
        total_h_pixel = 13'd12; total_v_pixel = 13'd8;
        pattern_sel = 2'd2; solid_rgb = 16'h1234;
        tx_en = 1'b1;
        n = 0;
        while (n < 5000 && !cam_href) begin @(negedge clk); n++; end
        chk("href_reached_before_reset", 32'(cam_href), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("midframe_reset_outputs",
            32'({cam_pclk, cam_vsync, cam_href, cam_data, frame_done, busy}), 32'd0);
        tx_en = 1'b0;
        mon_en = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("idle_after_reset", 32'({cam_pclk, busy}), 32'd0);

        // Back-to-back frames; each config is changed while the previous frame runs
        program_frame(cfgs[0], 0, th_eff[0]);
        tx_en = 1'b1;
        for (int k = 0; k < NF; k++) begin
            wait_vsync_rise("frame_start_timeout");
            if (k < NF - 1) begin
                program_frame(cfgs[k + 1], k + 1, th_eff[k + 1]);
            end else begin
                // Drop enable inside VBP; this frame must still complete
                repeat (8 * th_eff[k] + 20) @(negedge clk);
                tx_en = 1'b0;
                cmos_h_pixel = 13'd3;
            end
        end
        n = 0;
        while (frames_done < NF && n < 20000) begin @(negedge clk); n++; end
        chk("frames_completed", 32'(frames_done), 32'(NF));
        repeat (4) @(negedge clk);
        chk("idle_after_last_frame", 32'({busy, cam_pclk, cam_vsync, cam_href}), 32'd0);
        repeat (200) @(negedge clk);
        chk("stays_idle", 32'({busy, cam_pclk}), 32'd0);
        chk("no_extra_frames", 32'(frames_done), 32'(NF));
        chk("byte_queue_drained", 32'(byte_q.size()), 32'd0);
        chk("frame_queue_drained", 32'(exp_q.size()), 32'd0);
        ignore = th;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
